// File: rtl/tusca_pkg.sv
// Shared definitions for the DHT11 measurement sequencer: state codes and default parameters.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tusca_pkg;

  // State codes are visible on db_estado, so the numeric values are part of the interface.
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    CONFIG        = 4'd1,
    MEDE          = 4'd2,
    ESPERA_MEDIDA = 4'd3,
    TRANSMITE     = 4'd4,
    ESPERA_TX     = 4'd5,
    PROXIMO       = 4'd6,
    DELAY         = 4'd7
  } estado_t;

  // Defaults assume a 50 MHz clock: 2 s between rounds, 1 s per measurement attempt.
  localparam int N_CANAIS_PADRAO       = 2;
  localparam int PERIODO_DELAY_PADRAO  = 100_000_000;
  localparam int TIMEOUT_PADRAO        = 50_000_000;
  localparam int MAX_TENTATIVAS_PADRAO = 3;

  // Bits needed to hold 0..valor-1, never less than one bit.
  function automatic int largura(input int valor);
    return (valor > 1) ? $clog2(valor) : 1;
  endfunction

endpackage

// File: rtl/tusca_contador_m.sv
// Saturating up-counter over 0..MODULO-1 with synchronous clear, enable and terminal flag.
// Latency: fim rises in the cycle the stored value equals MODULO-1 (registered value, no input path).
// Backpressure: none; holds at MODULO-1 instead of wrapping.
module tusca_contador_m
  import tusca_pkg::*;
#(
  parameter int MODULO = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim
);

  localparam int            W      = largura(MODULO);
  localparam logic [W-1:0]  ULTIMO = W'(MODULO - 1);

  logic [W-1:0] valor;

  // Count up while enabled, stopping at the terminal value; clear has priority.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      valor <= '0;
    end else if (conta && (valor != ULTIMO)) begin
      valor <= valor + W'(1);
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/tusca_sequenciador.sv
// Round-robin DHT11 sequencer: measures each channel with retries and timeout, transmits results, idles between rounds.
// Latency: outputs decoded from registered state/channel, one cycle after the causing input edge.
// Backpressure: waits indefinitely for pronto_transmissao and pronto_config; measurements bounded by TIMEOUT.
module tusca_sequenciador
  import tusca_pkg::*;
#(
  parameter  int N_CANAIS       = N_CANAIS_PADRAO,
  parameter  int PERIODO_DELAY  = PERIODO_DELAY_PADRAO,
  parameter  int TIMEOUT        = TIMEOUT_PADRAO,
  parameter  int MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO,
  localparam int CW             = largura(N_CANAIS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                parar,
  input  logic                definir_config,
  input  logic                pronto_config,
  input  logic                pronto_medida,
  input  logic                erro_medida,
  input  logic                pronto_transmissao,
  output logic [N_CANAIS-1:0] medir,
  output logic [CW-1:0]       canal,
  output logic                receber_config,
  output logic                transmite_medida,
  output logic [N_CANAIS-1:0] erro_canal,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

  localparam int            TW              = largura(MAX_TENTATIVAS);
  localparam logic [CW-1:0] CANAL_FINAL     = CW'(N_CANAIS - 1);
  localparam logic [TW-1:0] TENTATIVA_FINAL = TW'(MAX_TENTATIVAS - 1);

  estado_t       estado;
  estado_t       proximo;
  logic [TW-1:0] tentativa;
  logic          parar_pendente;

  logic          fim_timeout;
  logic          fim_delay;
  logic          limpa_timeout;
  logic          conta_timeout;
  logic          limpa_delay;
  logic          conta_delay;

  logic          falha;
  logic          ultima_tentativa;
  logic          ultimo_canal;
  logic          encerrar;
  logic          em_rodada;

  // A timed-out attempt is treated exactly like an explicit sensor error.
  assign falha            = erro_medida | fim_timeout;
  assign ultima_tentativa = (tentativa == TENTATIVA_FINAL);
  assign ultimo_canal     = (canal == CANAL_FINAL);
  // A stop request arriving in PROXIMO itself is honoured immediately.
  assign encerrar         = parar_pendente | parar;
  assign em_rodada        = (estado == MEDE) || (estado == ESPERA_MEDIDA) ||
                            (estado == TRANSMITE) || (estado == ESPERA_TX) ||
                            (estado == PROXIMO);

  // Counter controls come only from the state register.
  assign limpa_timeout = (estado == MEDE);
  assign conta_timeout = (estado == ESPERA_MEDIDA);
  assign limpa_delay   = (estado == PROXIMO);
  assign conta_delay   = (estado == DELAY);

  tusca_contador_m #(
    .MODULO (TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa_timeout),
    .conta  (conta_timeout),
    .fim    (fim_timeout)
  );

  tusca_contador_m #(
    .MODULO (PERIODO_DELAY)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa_delay),
    .conta  (conta_delay),
    .fim    (fim_delay)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state selection.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: begin
        if (definir_config) begin
          proximo = CONFIG;
        end else if (start) begin
          proximo = MEDE;
        end
      end
      CONFIG: begin
        if (pronto_config) begin
          proximo = INICIAL;
        end
      end
      MEDE: begin
        proximo = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        if (pronto_medida) begin
          proximo = TRANSMITE;
        end else if (falha) begin
          proximo = ultima_tentativa ? PROXIMO : MEDE;
        end
      end
      TRANSMITE: begin
        proximo = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (pronto_transmissao) begin
          proximo = PROXIMO;
        end
      end
      PROXIMO: begin
        if (encerrar) begin
          proximo = INICIAL;
        end else if (ultimo_canal) begin
          proximo = DELAY;
        end else begin
          proximo = MEDE;
        end
      end
      DELAY: begin
        if (parar) begin
          proximo = INICIAL;
        end else if (definir_config) begin
          proximo = CONFIG;
        end else if (fim_delay) begin
          proximo = MEDE;
        end
      end
      default: begin
        proximo = INICIAL;
      end
    endcase
  end

  // Outputs decoded from the state register and the registered channel index.
  always_comb begin
    medir            = '0;
    receber_config   = 1'b0;
    transmite_medida = 1'b0;
    ocupado          = 1'b1;
    db_estado        = estado;
    case (estado)
      INICIAL: begin
        ocupado = 1'b0;
      end
      CONFIG: begin
        ocupado        = 1'b0;
        receber_config = 1'b1;
      end
      MEDE: begin
        medir[canal] = 1'b1;
      end
      TRANSMITE: begin
        transmite_medida = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Channel index, attempt count and per-channel failure flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      canal      <= '0;
      tentativa  <= '0;
      erro_canal <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          if (!definir_config && start) begin
            canal     <= '0;
            tentativa <= '0;
          end
        end
        ESPERA_MEDIDA: begin
          if (pronto_medida) begin
            erro_canal[canal] <= 1'b0;
          end else if (falha) begin
            if (ultima_tentativa) begin
              erro_canal[canal] <= 1'b1;
            end else begin
              tentativa <= tentativa + TW'(1);
            end
          end
        end
        PROXIMO: begin
          tentativa <= '0;
          if (encerrar || ultimo_canal) begin
            canal <= '0;
          end else begin
            canal <= canal + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Stop requests during a round wait here until the current channel finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      parar_pendente <= 1'b0;
    end else if (proximo == INICIAL) begin
      parar_pendente <= 1'b0;
    end else if (parar && em_rodada) begin
      parar_pendente <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tusca_sequenciador.sv
// Bench for tusca_sequenciador: reactive sensor/transmitter responder, cycle model, directed scenario checks.
module tb_tusca_sequenciador;

  localparam int NC = 3;
  localparam int PD = 20;
  localparam int TO = 10;
  localparam int MT = 2;

  localparam int S_INI  = 0;
  localparam int S_CFG  = 1;
  localparam int S_MEDE = 2;
  localparam int S_ESP  = 3;
  localparam int S_TX   = 4;
  localparam int S_ETX  = 5;
  localparam int S_PROX = 6;
  localparam int S_DLY  = 7;

  logic          clock;
  logic          reset;
  logic          start;
  logic          parar;
  logic          definir_config;
  logic          pronto_config;
  logic          pronto_medida;
  logic          erro_medida;
  logic          pronto_transmissao;
  logic [NC-1:0] medir;
  logic [1:0]    canal;
  logic          receber_config;
  logic          transmite_medida;
  logic [NC-1:0] erro_canal;
  logic          ocupado;
  logic [3:0]    db_estado;

  tusca_sequenciador #(
    .N_CANAIS       (NC),
    .PERIODO_DELAY  (PD),
    .TIMEOUT        (TO),
    .MAX_TENTATIVAS (MT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .parar              (parar),
    .definir_config     (definir_config),
    .pronto_config      (pronto_config),
    .pronto_medida      (pronto_medida),
    .erro_medida        (erro_medida),
    .pronto_transmissao (pronto_transmissao),
    .medir              (medir),
    .canal              (canal),
    .receber_config     (receber_config),
    .transmite_medida   (transmite_medida),
    .erro_canal         (erro_canal),
    .ocupado            (ocupado),
    .db_estado          (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_erros  = 0;

  // Responder behaviour selectors.
  bit modo_retry   = 1'b0;
  bit modo_timeout = 1'b0;

  // Observation logs.
  logic [2:0] med_log[$];
  int         tx_ch[4];
  int         dly_cnt;
  int         esp2_cnt;

  // Behavioural model: the sequencer as a set of plain counters.
  typedef struct {
    int         st;
    int         canal;
    int         tent;
    int         espera;
    bit         pend;
    logic [2:0] erro;
  } modelo_t;

  modelo_t mdl;
  bit      vivo = 1'b0;

  function automatic modelo_t passo(input modelo_t m, input logic rst, input logic st,
                                    input logic pa, input logic dc, input logic pc,
                                    input logic pm, input logic em, input logic pt);
    modelo_t n;
    n = m;
    if (rst) begin
      n.st = S_INI; n.canal = 0; n.tent = 0; n.espera = 0; n.pend = 1'b0; n.erro = 3'b000;
      return n;
    end
    if (pa && m.st >= S_MEDE && m.st <= S_PROX) n.pend = 1'b1;
    case (m.st)
      S_INI: begin
        if (dc) n.st = S_CFG;
        else if (st) begin n.st = S_MEDE; n.canal = 0; n.tent = 0; end
      end
      S_CFG: if (pc) n.st = S_INI;
      S_MEDE: begin n.espera = 0; n.st = S_ESP; end
      S_ESP: begin
        n.espera = m.espera + 1;
        if (pm) begin
          n.erro[m.canal] = 1'b0; n.st = S_TX;
        end else if (em || n.espera == TO) begin
          if (m.tent + 1 < MT) begin n.tent = m.tent + 1; n.st = S_MEDE; end
          else begin n.erro[m.canal] = 1'b1; n.st = S_PROX; end
        end
      end
      S_TX: n.st = S_ETX;
      S_ETX: if (pt) n.st = S_PROX;
      S_PROX: begin
        n.tent = 0;
        if (n.pend) begin n.st = S_INI; n.canal = 0; end
        else if (m.canal == NC - 1) begin n.canal = 0; n.espera = 0; n.st = S_DLY; end
        else begin n.canal = m.canal + 1; n.st = S_MEDE; end
      end
      S_DLY: begin
        n.espera = m.espera + 1;
        if (pa) n.st = S_INI;
        else if (dc) n.st = S_CFG;
        else if (n.espera == PD) n.st = S_MEDE;
      end
      default: n.st = S_INI;
    endcase
    if (n.st == S_INI) n.pend = 1'b0;
    return n;
  endfunction

  always @(posedge clock) begin
    mdl  <= passo(mdl, reset, start, parar, definir_config, pronto_config,
                  pronto_medida, erro_medida, pronto_transmissao);
    vivo <= vivo | reset;
  end

  // Sensor and transmitter stand-in: pronto_medida 3 cycles after medir, pronto_transmissao 2 after transmite_medida.
  initial begin
    int cd_med;
    int cd_tx;
    int tipo;
    int ch;
    int n_med[NC];
    pronto_medida = 1'b0; erro_medida = 1'b0; pronto_transmissao = 1'b0;
    cd_med = 0; cd_tx = 0; tipo = 0; ch = 0;
    for (int i = 0; i < NC; i++) n_med[i] = 0;
    forever begin
      @(negedge clock);
      pronto_medida = 1'b0; erro_medida = 1'b0; pronto_transmissao = 1'b0;
      if (reset) begin
        cd_med = 0; cd_tx = 0;
        for (int i = 0; i < NC; i++) n_med[i] = 0;
      end else begin
        if (cd_med > 0) begin
          cd_med--;
          if (cd_med == 0) begin
            if (tipo == 1) erro_medida = 1'b1;
            else pronto_medida = 1'b1;
          end
        end
        if (cd_tx > 0) begin
          cd_tx--;
          if (cd_tx == 0) pronto_transmissao = 1'b1;
        end
        if (medir != 0) begin
          ch = medir[0] ? 0 : (medir[1] ? 1 : 2);
          if (ch == 0) begin n_med[1] = 0; n_med[2] = 0; end
          tipo = (modo_retry && ch == 1 && n_med[1] == 0) ? 1 : 0;
          if (!(modo_timeout && ch == 2)) cd_med = 3;
          n_med[ch]++;
        end
        if (transmite_medida) cd_tx = 2;
      end
    end
  end

  // One cycle: compare against the model and log at the falling edge, then step past it.
  task automatic tick();
    logic [2:0] e_medir;
    logic [2:0] um;
    @(negedge clock);
    if (vivo) begin
      um      = 3'b001;
      e_medir = (mdl.st == S_MEDE) ? (um << mdl.canal) : 3'b000;
      n_checks++;
      if (db_estado !== 4'(mdl.st) || medir !== e_medir || canal !== 2'(mdl.canal) ||
          receber_config !== (mdl.st == S_CFG) || transmite_medida !== (mdl.st == S_TX) ||
          erro_canal !== mdl.erro || ocupado !== (mdl.st >= S_MEDE)) begin
        n_erros++;
        $display("FAIL modelo t=%0t: obtido est=%0d medir=%b canal=%0d rc=%b tx=%b erro=%b oc=%b; esperado est=%0d medir=%b canal=%0d erro=%b",
                 $time, db_estado, medir, canal, receber_config, transmite_medida, erro_canal, ocupado,
                 mdl.st, e_medir, mdl.canal, mdl.erro);
      end
    end
    if (medir != 0) med_log.push_back(medir);
    if (transmite_medida) tx_ch[canal]++;
    if (db_estado == 4'(S_DLY)) dly_cnt++;
    if (db_estado == 4'(S_ESP) && canal == 2'd2) esp2_cnt++;
    #1;
  endtask

  task automatic verifica(input string nome, input int obtido, input int esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s: obtido=%0d esperado=%0d", nome, obtido, esperado);
    end
  endtask

  task automatic espera_estado(input int alvo, input int limite, input string nome);
    int k;
    k = 0;
    while (int'(db_estado) != alvo && k < limite) begin
      tick();
      k++;
    end
    if (int'(db_estado) != alvo) begin
      n_checks++;
      n_erros++;
      $display("FAIL %s: estado=%0d esperado=%0d apos %0d ciclos", nome, db_estado, alvo, limite);
    end
  endtask

  task automatic limpa_logs();
    med_log.delete();
    for (int i = 0; i < 4; i++) tx_ch[i] = 0;
    dly_cnt  = 0;
    esp2_cnt = 0;
  endtask

  function automatic int conta_log(input logic [2:0] v);
    int c;
    c = 0;
    foreach (med_log[i]) if (med_log[i] == v) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; parar = 1'b0; definir_config = 1'b0; pronto_config = 1'b0;
    limpa_logs();
    repeat (3) tick();
    verifica("reset_estado", db_estado, 0);
    verifica("reset_medir", medir, 0);
    verifica("reset_canal", canal, 0);
    verifica("reset_erro", erro_canal, 0);
    verifica("reset_ocupado", ocupado, 0);
    verifica("reset_tx", transmite_medida, 0);
    reset = 1'b0;
    tick();
    verifica("ocioso_inicial", db_estado, 0);

    // Happy path: all three channels, then 20 cycles of DELAY, then channel 0 again.
    limpa_logs();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 300 && med_log.size() < 4; i++) tick();
    verifica("feliz_n_medir", med_log.size(), 4);
    if (med_log.size() == 4) begin
      verifica("feliz_medir0", med_log[0], 1);
      verifica("feliz_medir1", med_log[1], 2);
      verifica("feliz_medir2", med_log[2], 4);
      verifica("feliz_medir3", med_log[3], 1);
    end
    verifica("feliz_tx0", tx_ch[0], 1);
    verifica("feliz_tx1", tx_ch[1], 1);
    verifica("feliz_tx2", tx_ch[2], 1);
    verifica("feliz_delay", dly_cnt, 20);

    // Retry: channel 1 errs on the first attempt, succeeds on the second.
    modo_retry = 1'b1;
    limpa_logs();
    espera_estado(S_DLY, 300, "retry_chega_delay");
    verifica("retry_medir010", conta_log(3'b010), 2);
    verifica("retry_medir100", conta_log(3'b100), 1);
    verifica("retry_tx1", tx_ch[1], 1);
    verifica("retry_erro", erro_canal, 0);

    // Timeout: channel 2 never answers.
    modo_retry   = 1'b0;
    modo_timeout = 1'b1;
    limpa_logs();
    espera_estado(S_MEDE, 40, "timeout_sai_delay");
    espera_estado(S_DLY, 300, "timeout_chega_delay");
    verifica("timeout_medir100", conta_log(3'b100), 2);
    verifica("timeout_espera", esp2_cnt, 20);
    verifica("timeout_tx2", tx_ch[2], 0);
    verifica("timeout_tx1", tx_ch[1], 1);
    verifica("timeout_erro", erro_canal, 4);
    verifica("timeout_canal", canal, 0);

    // Stop during channel 0's transmission wait.
    modo_timeout = 1'b0;
    limpa_logs();
    espera_estado(S_ETX, 300, "parar_chega_etx");
    verifica("parar_canal_etx", canal, 0);
    parar = 1'b1; tick(); parar = 1'b0;
    espera_estado(S_INI, 50, "parar_chega_inicial");
    repeat (5) tick();
    verifica("parar_fica_inicial", db_estado, 0);
    verifica("parar_tx0", tx_ch[0], 1);
    verifica("parar_sem_010", conta_log(3'b010), 0);
    verifica("parar_n_medir", med_log.size(), 1);
    verifica("parar_canal", canal, 0);
    verifica("parar_ocupado", ocupado, 0);
    verifica("parar_erro_mantido", erro_canal, 4);

    // Configuration requested from DELAY.
    start = 1'b1; tick(); start = 1'b0;
    espera_estado(S_DLY, 300, "config_chega_delay");
    verifica("config_erro_reescrito", erro_canal, 0);
    definir_config = 1'b1; tick(); definir_config = 1'b0;
    verifica("config_estado", db_estado, 1);
    verifica("config_receber", receber_config, 1);
    verifica("config_ocupado", ocupado, 0);
    start = 1'b1; parar = 1'b1; tick(); start = 1'b0; parar = 1'b0;
    tick();
    verifica("config_ignora_start", db_estado, 1);
    verifica("config_receber_mantido", receber_config, 1);
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    verifica("config_volta_inicial", db_estado, 0);
    verifica("config_receber_fim", receber_config, 0);

    // Reset in the middle of a measurement, then start together with definir_config.
    start = 1'b1; tick(); start = 1'b0;
    espera_estado(S_ESP, 20, "rst_chega_espera");
    limpa_logs();
    reset = 1'b1; tick();
    verifica("rst_meio_estado", db_estado, 0);
    verifica("rst_meio_medir", medir, 0);
    verifica("rst_meio_tx", transmite_medida, 0);
    verifica("rst_meio_ocupado", ocupado, 0);
    verifica("rst_meio_receber", receber_config, 0);
    verifica("rst_meio_canal", canal, 0);
    reset = 1'b0; start = 1'b1; definir_config = 1'b1;
    tick();
    start = 1'b0; definir_config = 1'b0;
    verifica("rst_config_prioridade", db_estado, 1);
    tick();
    verifica("rst_sem_medir", med_log.size(), 0);
    verifica("rst_sem_tx", tx_ch[0] + tx_ch[1] + tx_ch[2], 0);
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    verifica("rst_final_inicial", db_estado, 0);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule
